// File: rtl/wave_phase_gen.sv
// wave_phase_gen
//   Phase-accumulator waveform source. It emits signed Q1.14 samples (+1.0 = 16384) in
//   sawtooth, square or triangle shape, or a constant zero. A programmable divider sets
//   the sample rate, and burst mode stops the run after a set number of waveform periods.
//   All configuration is captured when start is pulsed, so later changes on the inputs
//   do not disturb a run in progress.
//
// Ports
//   clk           system clock; all logic runs on posedge
//   rst_n         synchronous active-low reset
//   start         pulse: latch config, load phase_offset, enter RUN (restarts if running)
//   stop          pulse: abort to IDLE and clear sample_out; wins over start
//   wave_sel      0 sawtooth, 1 square, 2 triangle, 3 zero
//   tuning_word   phase increment per sample tick
//   phase_offset  phase loaded at start
//   sample_div    one tick every sample_div+1 cycles
//   burst_cycles  periods to emit; 0 = continuous
//   sample_out    signed Q1.14 sample
//   sample_valid  1-cycle strobe when sample_out updates
//   busy          high while in RUN
//   done          1-cycle pulse when a burst completes
//   cycle_count   periods completed in the current or last run
module wave_phase_gen #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         wave_sel,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic [PHASE_W-1:0] phase_offset,
    input  logic [DIV_W-1:0]   sample_div,
    input  logic [BURST_W-1:0] burst_cycles,
    output logic [OUT_W-1:0]   sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] cycle_count
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [PHASE_W-1:0] tuning_q, tuning_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic [OUT_W-1:0]   sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [PHASE_W:0]   sum;       // carry bit marks a period wrap
    logic [15:0]        u;
    logic [OUT_W-1:0]   shape;
    logic [BURST_W-1:0] count_inc;

    always_comb begin
        u   = phase_q[PHASE_W-1 -: 16];
        sum = {1'b0, phase_q} + {1'b0, tuning_q};
        // Every shape lands in -16384..16384, so 16-bit wrap-around arithmetic is exact.
        case (sel_q)
            2'd0:    shape = {1'b0, u[15:1]} - 16'd16384;
            2'd1:    shape = u[15] ? 16'hC000 : 16'h4000;
            2'd2:    shape = u[15] ? (16'd49151 - u) : (u - 16'd16384);
            default: shape = '0;
        endcase
        count_inc = (&count_q) ? count_q : count_q + BURST_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tuning_d  = tuning_q;
        div_d     = div_q;
        burst_d   = burst_q;
        phase_d   = phase_q;
        div_cnt_d = div_cnt_q;
        count_d   = count_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;

        if (stop) begin
            state_d  = StIdle;
            sample_d = '0;
        end else if (start) begin
            sel_d     = wave_sel;
            tuning_d  = tuning_word;
            div_d     = sample_div;
            burst_d   = burst_cycles;
            phase_d   = phase_offset;
            div_cnt_d = '0;
            count_d   = '0;
            state_d   = StRun;
        end else if (state_q == StRun) begin
            if (div_cnt_q == div_q) begin
                div_cnt_d = '0;
                sample_d  = shape;
                valid_d   = 1'b1;
                phase_d   = sum[PHASE_W-1:0];
                if (sum[PHASE_W]) begin
                    count_d = count_inc;
                    if ((burst_q != '0) && (count_inc == burst_q)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            // Idle or done: clears the last burst sample one cycle after completion.
            sample_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            tuning_q  <= '0;
            div_q     <= '0;
            burst_q   <= '0;
            phase_q   <= '0;
            div_cnt_q <= '0;
            count_q   <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tuning_q  <= tuning_d;
            div_q     <= div_d;
            burst_q   <= burst_d;
            phase_q   <= phase_d;
            div_cnt_q <= div_cnt_d;
            count_q   <= count_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q == StRun);
    assign done         = done_q;
    assign cycle_count  = count_q;

endmodule

// File: tb/tb_wave_phase_gen.sv
// Bench for wave_phase_gen. Each run's expected samples (value, edge, done flag and
// cycle_count) are pushed to a queue when start is driven; a negedge monitor pops and
// compares one entry per sample_valid and flags any unexpected valid or done.
module tb_wave_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  wave_sel = '0;
    logic [31:0] tuning_word = '0;
    logic [31:0] phase_offset = '0;
    logic [15:0] sample_div = '0;
    logic [15:0] burst_cycles = '0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        done;
    logic [15:0] cycle_count;

    wave_phase_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .wave_sel    (wave_sel),
        .tuning_word (tuning_word),
        .phase_offset(phase_offset),
        .sample_div  (sample_div),
        .burst_cycles(burst_cycles),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .done        (done),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int s;
        int d;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   sedge;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int shape_ref(input int sel, input logic [31:0] ph);
        int uu;
        uu = int'(ph[31:16]);
        case (sel)
            0:       return uu / 2 - 16384;
            1:       return (uu < 32768) ? 16384 : -16384;
            2:       return (uu < 32768) ? uu - 16384 : 49151 - uu;
            default: return 0;
        endcase
    endfunction

    // Expected samples of a run started at edge base.
    function automatic void push_run(input int sel, input logic [31:0] tw, input logic [31:0] off,
                                     input int div, input int burst, input int n, input int base);
        logic [32:0] ph;
        int          cnt;
        exp_t        e;
        ph  = {1'b0, off};
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            e.s   = shape_ref(sel, ph[31:0]);
            e.cyc = base + (div + 1) * (k + 1);
            ph    = {1'b0, ph[31:0]} + {1'b0, tw};
            if (ph[32] && cnt != 65535) cnt++;
            e.cnt = cnt;
            e.d   = (burst != 0 && ph[32] && cnt == burst) ? 1 : 0;
            q.push_back(e);
            if (e.d != 0) break;
        end
    endfunction

    task automatic do_start(input int sel, input logic [31:0] tw, input logic [31:0] off,
                            input int div, input int burst);
        @(negedge clk);
        wave_sel     = sel[1:0];
        tuning_word  = tw;
        phase_offset = off;
        sample_div   = div[15:0];
        burst_cycles = burst[15:0];
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sedge = cyc;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sample_valid) begin
            if (q.size() == 0) begin
                check("valid_expected", q.size() != 0, 1);
            end else begin
                mon_e = q.pop_front();
                check("sample", $signed(sample_out), mon_e.s);
                check("valid_cyc", cyc, mon_e.cyc);
                check("done_with_sample", done, mon_e.d);
                check("cycle_count_at_sample", cycle_count, mon_e.cnt);
            end
        end else begin
            check("done_without_sample", done, 0);
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sample", sample_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", cycle_count, 0);
        rst_n = 1'b1;

        // 1: sawtooth, tick every cycle, continuous
        do_start(0, 32'h4000_0000, 32'h0, 0, 0);
        push_run(0, 32'h4000_0000, 32'h0, 0, 0, 8, sedge);
        check("t1_busy", busy, 1);
        repeat (8) @(posedge clk);
        do_stop();
        check("t1_busy_after_stop", busy, 0);
        check("t1_sample_after_stop", sample_out, 0);
        check("t1_count_held", cycle_count, 2);
        check("t1_q_empty", q.size(), 0);

        // 2: square, div 3, burst of 2 periods
        do_start(1, 32'h4000_0000, 32'h0, 3, 2);
        push_run(1, 32'h4000_0000, 32'h0, 3, 2, 8, sedge);
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("t2_busy_after_done", busy, 0);
        @(negedge clk);
        check("t2_sample_cleared", sample_out, 0);
        check("t2_count", cycle_count, 2);
        repeat (8) @(posedge clk);
        check("t2_q_empty", q.size(), 0);

        // 3: triangle from mid-phase, div 1
        do_start(2, 32'h2000_0000, 32'h8000_0000, 1, 0);
        push_run(2, 32'h2000_0000, 32'h8000_0000, 1, 0, 8, sedge);
        repeat (16) @(posedge clk);
        do_stop();
        check("t3_q_empty", q.size(), 0);

        // 4: stop together with start on the 3rd tick edge
        do_start(1, 32'h4000_0000, 32'h0, 1, 0);
        push_run(1, 32'h4000_0000, 32'h0, 1, 0, 2, sedge);
        repeat (5) @(posedge clk);
        @(negedge clk);
        stop        = 1'b1;
        start       = 1'b1;
        tuning_word = 32'h1000_0000;
        @(posedge clk);
        #1;
        stop  = 1'b0;
        start = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_sample", sample_out, 0);
        check("t4_done", done, 0);
        repeat (10) @(posedge clk);
        #1;
        check("t4_still_idle", busy, 0);
        check("t4_q_empty", q.size(), 0);

        // 5: restart mid-run with a new offset and tuning word
        do_start(0, 32'h4000_0000, 32'hC000_0000, 2, 0);
        push_run(0, 32'h4000_0000, 32'hC000_0000, 2, 0, 3, sedge);
        repeat (9) @(posedge clk);
        check("t5_count_before", cycle_count, 1);
        do_start(0, 32'h1000_0000, 32'h8000_0000, 2, 0);
        push_run(0, 32'h1000_0000, 32'h8000_0000, 2, 0, 4, sedge);
        check("t5_count_reset", cycle_count, 0);
        check("t5_busy", busy, 1);
        repeat (12) @(posedge clk);
        do_stop();
        check("t5_q_empty", q.size(), 0);

        // 6: reset mid-burst
        do_start(1, 32'h4000_0000, 32'h0, 0, 3);
        push_run(1, 32'h4000_0000, 32'h0, 0, 3, 5, sedge);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_sample", sample_out, 0);
        check("t6_busy", busy, 0);
        check("t6_valid", sample_valid, 0);
        check("t6_count", cycle_count, 0);
        repeat (15) @(posedge clk);
        #1;
        check("t6_still_idle", busy, 0);
        check("t6_q_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wave_phase_gen.md
Name: wave_phase_gen

Overview:
- Phase-accumulator waveform source for the wavegen datapath.
- Produces signed Q1.14 samples (+1.0 = 16384), which feed the fixed-point multiplier's x operand for amplitude scaling.
- Supports sawtooth, square and triangle shapes, a programmable sample-rate divider, and burst mode (N waveform periods, then stop).
- Configuration is captured at start, so bus writes during a run do not corrupt the waveform.

Parameters:
PHASE_W, 32, phase accumulator width (bits)
OUT_W, 16, sample width; fixed at 16 for the Q1.14 format
DIV_W, 16, sample divider width
BURST_W, 16, burst/period counter width

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse: latch config, begin run
stop  in  1  single-cycle pulse: abort run, go idle
wave_sel  in  2  0=sawtooth, 1=square, 2=triangle, 3=zero
tuning_word  in  PHASE_W  phase increment per sample tick
phase_offset  in  PHASE_W  initial phase loaded at start
sample_div  in  DIV_W  one tick every sample_div+1 cycles
burst_cycles  in  BURST_W  periods to emit; 0 = continuous
sample_out  out  16  signed Q1.14 sample
sample_valid  out  1  1-cycle strobe, sample_out updated
busy  out  1  high in RUN
done  out  1  1-cycle pulse on burst completion
cycle_count  out  BURST_W  completed periods in current/last run

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; phase, div counter and cycle_count = 0; sample_out = 0; sample_valid, busy and done = 0.
- States: IDLE, RUN, DONE. The DONE state behaves as IDLE except for its source (a completed burst).
- Priority per edge: reset > stop > start > tick.
- stop in any state: go to IDLE, sample_out <= 0, no done pulse. stop and start in the same cycle: stop wins.
- start in any state (including RUN, i.e. restart):
  - latch wave_sel, tuning_word, sample_div, burst_cycles;
  - phase <= phase_offset; div counter and cycle_count <= 0;
  - go to RUN; busy = 1 from the next cycle.
- Tick generation in RUN:
  - The div counter increments each cycle.
  - A tick occurs when counter == latched sample_div; the counter then resets to 0.
  - The first tick therefore falls sample_div+1 cycles after the start edge. sample_div = 0 gives a tick every cycle.
- On a tick edge:
  - sample_out <= shape(phase) of the current (pre-increment) phase; sample_valid = 1 for that cycle.
  - phase <= phase + tuning_word, modulo 2^PHASE_W.
- Period wrap: the carry out of that addition increments cycle_count, saturating at all-ones.
- Burst completion:
  - Condition: burst_cycles != 0 and a wrap makes cycle_count reach burst_cycles.
  - At that same edge the sample is still emitted (valid = 1), the state goes to DONE, done = 1, and busy drops the next cycle.
  - On the following edge sample_out <= 0.
- Shape, using u = phase[PHASE_W-1 -: 16] as unsigned:
  - sawtooth: (u>>1) - 16384, range -16384..16383
  - square: +16384 if u[15]==0, else -16384
  - triangle: u - 16384 if u < 32768, else 49151 - u, range -16384..16383, continuous at both seams
  - zero: 0
- Every result fits signed 16 bits; no saturation logic is needed.
- sample_valid is low in IDLE/DONE and on non-tick cycles.
- tuning_word = 0: output is constant shape(phase_offset); a burst never completes (stop required).
- cycle_count holds its value in IDLE/DONE until the next start or reset.
- Reset mid-RUN: immediate return to reset state; no done pulse.

Test Plan:
1. Sawtooth, tuning_word=0x40000000, offset=0, div=0, burst=0, start -> valid every cycle from cycle 1; samples -16384, -8192, 0, 8192, -16384, ...; cycle_count increments on every 4th sample.
2. Square, tuning_word=0x40000000, div=3, burst=2 -> valid every 4 cycles; samples +16384, +16384, -16384, -16384, repeated; done pulses with the 8th valid; busy falls; sample_out = 0 one cycle later; cycle_count = 2.
3. Triangle, tuning_word=0x20000000, offset=0x80000000 -> samples 16383, 8191, -1, -8193, -16384, -8192, 0, 8192.
4. Stop asserted during RUN at the 3rd valid, with start in the same cycle -> IDLE, busy = 0, sample_out = 0, no done pulse, no further valids.
5. start re-pulsed mid-run with a new offset 0x80000000 (sawtooth) -> cycle_count = 0; the next sample after sample_div+1 cycles is 0; the new config takes effect.
6. rst_n low for 1 cycle mid-burst -> all outputs 0; done never pulses; holds idle until the next start.
